// File: rtl/fp_mul_out_stage.sv
// Registered output stage behind the FP multiplier: 2-entry skid buffer with registered
// in_ready, plus sticky class flags and saturating NaN/infinity counters for polling.
module fp_mul_out_stage #(
  parameter  int NEXP      = 5,
  parameter  int NSIG      = 10,
  parameter  int CNTW      = 8,
  // class flag bit map shared with the multiplier (ZERO=3, SUBNORMAL=4, NORMAL=5)
  localparam int LAST_FLAG = 6,
  localparam int SNAN      = 0,
  localparam int QNAN      = 1,
  localparam int INFINITY  = 2,
  localparam int PW        = NEXP + NSIG + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PW-1:0]        in_p,
  input  logic [LAST_FLAG-1:0] in_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_p,
  output logic [LAST_FLAG-1:0] out_flags,
  input  logic                 clr,
  output logic [LAST_FLAG-1:0] sticky,
  output logic                 flag_err,
  output logic [CNTW-1:0]      nan_cnt,
  output logic [CNTW-1:0]      inf_cnt,
  output logic [1:0]           occupancy
);

  typedef struct packed {
    logic [PW-1:0]        p;
    logic [LAST_FLAG-1:0] flags;
  } entry_t;

  entry_t head, skid, inEnt;
  logic [1:0] occ, nextOcc;
  logic outValid, inReady, acc, pop;

  assign inEnt = '{p: in_p, flags: in_flags};
  assign acc   = in_valid & inReady;
  assign pop   = outValid & out_ready;

  always_comb begin
    nextOcc = occ;
    case (occ)
      2'd0:    if (acc) nextOcc = 2'd1;
      2'd1:    if (acc && !pop) nextOcc = 2'd2;
               else if (!acc && pop) nextOcc = 2'd0;
      default: if (pop) nextOcc = 2'd1;
    endcase
  end

  // in_ready is derived from the next occupancy so it is a flop, not a comb path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      skid     <= '0;
      occ      <= 2'd0;
      outValid <= 1'b0;
      inReady  <= 1'b1;
    end else begin
      occ      <= nextOcc;
      outValid <= (nextOcc != 2'd0);
      inReady  <= (nextOcc != 2'd2);
      case (occ)
        2'd0:    if (acc) head <= inEnt;
        2'd1:    if (acc && pop) head <= inEnt;
                 else if (acc) skid <= inEnt;
        default: if (pop) head <= skid;
      endcase
    end
  end

  logic [LAST_FLAG-1:0] stickyBase, stickyNext;
  logic [CNTW-1:0]      nanBase, infBase, nanNext, infNext;
  logic                 errBase, errNext, notOneHot, isNan, isInf;

  assign notOneHot = (in_flags == '0) || ((in_flags & (in_flags - LAST_FLAG'(1))) != '0);
  assign isNan     = in_flags[SNAN] | in_flags[QNAN];
  assign isInf     = in_flags[INFINITY];

  // clear takes effect first so a same-cycle accepted result is still recorded
  always_comb begin
    stickyBase = clr ? '0 : sticky;
    errBase    = clr ? 1'b0 : flag_err;
    nanBase    = clr ? '0 : nan_cnt;
    infBase    = clr ? '0 : inf_cnt;
    stickyNext = stickyBase;
    errNext    = errBase;
    nanNext    = nanBase;
    infNext    = infBase;
    if (acc) begin
      stickyNext = stickyBase | in_flags;
      errNext    = errBase | notOneHot;
      if (isNan && nanBase != '1) nanNext = nanBase + CNTW'(1);
      if (isInf && infBase != '1) infNext = infBase + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky   <= '0;
      flag_err <= 1'b0;
      nan_cnt  <= '0;
      inf_cnt  <= '0;
    end else begin
      sticky   <= stickyNext;
      flag_err <= errNext;
      nan_cnt  <= nanNext;
      inf_cnt  <= infNext;
    end
  end

  assign in_ready  = inReady;
  assign out_valid = outValid;
  assign out_p     = head.p;
  assign out_flags = head.flags;
  assign occupancy = occ;

endmodule

// File: tb/tb_fp_mul_out_stage.sv
// Directed bench for fp_mul_out_stage: handshake, ordering under backpressure,
// streaming, counter saturation, clear collision and async reset.
module tb_fp_mul_out_stage;
  localparam logic [5:0] F_QNAN = 6'b000010;
  localparam logic [5:0] F_INF  = 6'b000100;
  localparam logic [5:0] F_NORM = 6'b100000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
  logic [15:0] in_p = '0;
  logic [5:0]  in_flags = '0;
  logic        in_ready, out_valid, flag_err;
  logic [15:0] out_p;
  logic [5:0]  out_flags, sticky;
  logic [7:0]  nan_cnt, inf_cnt;
  logic [1:0]  occupancy;

  int nVec = 0, nErr = 0;

  fp_mul_out_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
    .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_flags(out_flags), .clr(clr), .sticky(sticky), .flag_err(flag_err),
    .nan_cnt(nan_cnt), .inf_cnt(inf_cnt), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int badReady, sawFull;
    logic [15:0] expP;

    // reset state
    #12;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst occupancy", 32'(occupancy), 0);
    chk("rst sticky", 32'(sticky), 0);
    chk("rst counters", {nan_cnt, inf_cnt}, 0);
    chk("rst out_p", 32'(out_p), 0);
    step();
    rst = 1'b0;

    // 1: single pass, latency 1
    in_valid = 1'b1; in_p = 16'h3C00; in_flags = F_NORM; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1 out_valid", 32'(out_valid), 1);
    chk("t1 out_p", 32'(out_p), 32'h3C00);
    chk("t1 out_flags", 32'(out_flags), 32'(F_NORM));
    chk("t1 occ1", 32'(occupancy), 1);
    step();
    chk("t1 occ0", 32'(occupancy), 0);
    chk("t1 drained", 32'(out_valid), 0);
    chk("t1 sticky", 32'(sticky), 32'(F_NORM));

    // 2: backpressure, A B accepted, C held
    out_ready = 1'b0; in_valid = 1'b1; in_p = 16'hAAAA;
    step(); in_p = 16'hBBBB;
    chk("t2 ready after A", 32'(in_ready), 1);
    step(); in_p = 16'hCCCC;
    chk("t2 ready after B", 32'(in_ready), 0);
    chk("t2 occ full", 32'(occupancy), 2);
    step();
    chk("t2 C held, still full", 32'(occupancy), 2);
    chk("t2 head stable", 32'(out_p), 32'hAAAA);
    out_ready = 1'b1;
    step();
    chk("t2 out B", {15'd0, out_valid, out_p}, {15'd0, 1'b1, 16'hBBBB});
    chk("t2 ready reopens", 32'(in_ready), 1);
    step(); in_valid = 1'b0;
    chk("t2 out C", {15'd0, out_valid, out_p}, {15'd0, 1'b1, 16'hCCCC});
    step();
    chk("t2 drained", 32'(occupancy), 0);

    // 3: streaming 100 results
    badReady = 0; sawFull = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_p = 16'(i * 37 + 5);
      expP = in_p;
      step();
      chk("t3 stream data", {15'd0, out_valid, out_p}, {15'd0, 1'b1, expP});
      if (!in_ready) badReady++;
      if (occupancy == 2'd2) sawFull++;
    end
    in_valid = 1'b0;
    step();
    chk("t3 in_ready drops", 32'(badReady), 0);
    chk("t3 occ reached 2", 32'(sawFull), 0);
    chk("t3 drained", 32'(occupancy), 0);

    // 4: counter saturation
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4 clr counters", {nan_cnt, inf_cnt}, 0);
    chk("t4 clr sticky", 32'(sticky), 0);
    in_valid = 1'b1; in_flags = F_QNAN; in_p = 16'h7E01;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 254) chk("t4 nan 255", 32'(nan_cnt), 255);
      if (i == 9) chk("t4 nan 10", 32'(nan_cnt), 10);
    end
    in_valid = 1'b0;
    step();
    chk("t4 nan saturated", 32'(nan_cnt), 255);
    chk("t4 inf", 32'(inf_cnt), 0);
    chk("t4 sticky", 32'(sticky), 32'(F_QNAN));
    chk("t4 nan payload", 32'(out_p), 32'h7E01);
    chk("t4 flag_err", 32'(flag_err), 0);

    // 5: clr collides with accepted INF, then non-one-hot flags
    clr = 1'b1; in_valid = 1'b1; in_flags = F_INF; in_p = 16'hFC00;
    step(); clr = 1'b0; in_valid = 1'b0;
    chk("t5 sticky", 32'(sticky), 32'(F_INF));
    chk("t5 inf", 32'(inf_cnt), 1);
    chk("t5 nan", 32'(nan_cnt), 0);
    chk("t5 err clean", 32'(flag_err), 0);
    in_valid = 1'b1; in_flags = 6'b000000;
    step(); in_valid = 1'b0;
    chk("t5 err zero flags", 32'(flag_err), 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t5 err cleared", 32'(flag_err), 0);
    in_valid = 1'b1; in_flags = 6'b100100;
    step(); in_valid = 1'b0;
    chk("t5 err two-hot", 32'(flag_err), 1);
    chk("t5 inf two-hot", 32'(inf_cnt), 1);

    // 6: async reset while full
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_flags = F_INF; in_p = 16'h1111;
    step(); in_p = 16'h2222;
    step(); in_valid = 1'b0;
    chk("t6 full", 32'(occupancy), 2);
    #2 rst = 1'b1;
    #1;
    chk("t6 out_valid", 32'(out_valid), 0);
    chk("t6 in_ready", 32'(in_ready), 1);
    chk("t6 occ", 32'(occupancy), 0);
    chk("t6 counters", {nan_cnt, inf_cnt}, 0);
    chk("t6 sticky err", {26'd0, flag_err, sticky}, 0);
    #1 rst = 1'b0;
    step();
    in_valid = 1'b1; in_p = 16'h4242; in_flags = F_NORM; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    chk("t6 first after rst", {15'd0, out_valid, out_p}, {15'd0, 1'b1, 16'h4242});
    step();
    chk("t6 drained", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
